// File: rtl/compare_flag_gen_serial.sv
// Digit-serial A-B subtractor producing ALU compare flags.
// Ports: clk, rst_n, start, a, b -> busy, valid, diff, a_s, b_s, s_s, eq, ltu.
module compare_flag_gen_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             a_s,
  output logic             b_s,
  output logic             s_s,
  output logic             eq,
  output logic             ltu
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             eqacc_q, eqacc_d;
  logic             as_q, as_d;
  logic             bs_q, bs_d;
  logic             ss_q, ss_d;
  logic             eq_q, eq_d;
  logic             ltu_q, ltu_d;

  logic [DIGIT:0]   sum;
  logic [DIGIT-1:0] dig;
  logic             cout;
  logic             dig_z;
  logic [WIDTH-1:0] shifted;

  // One DIGIT-wide adder slice; B is stored inverted so
  // A + ~B + 1 yields A - B across all slices.
  assign sum = {1'b0, a_q[DIGIT-1:0]}
             + {1'b0, nb_q[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry_q};
  assign dig   = sum[DIGIT-1:0];
  assign cout  = sum[DIGIT];
  assign dig_z = (dig == '0);

  // New digit enters at the top; after N steps the
  // first (least significant) digit has reached bit 0.
  assign shifted = WIDTH'({dig, acc_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    eqacc_d = eqacc_q;
    as_d    = as_q;
    bs_d    = bs_q;
    ss_d    = ss_q;
    eq_d    = eq_q;
    ltu_d   = ltu_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          nb_d    = ~b;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          eqacc_d = 1'b1;
          as_d    = a[WIDTH-1];
          bs_d    = b[WIDTH-1];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        nb_d    = nb_q >> DIGIT;
        acc_d   = shifted;
        carry_d = cout;
        eqacc_d = eqacc_q & dig_z;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = shifted;
          ss_d    = shifted[WIDTH-1];
          eq_d    = eqacc_q & dig_z;
          ltu_d   = ~cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      eqacc_q <= 1'b0;
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      ss_q    <= 1'b0;
      eq_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      eqacc_q <= eqacc_d;
      as_q    <= as_d;
      bs_q    <= bs_d;
      ss_q    <= ss_d;
      eq_q    <= eq_d;
      ltu_q   <= ltu_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign valid = (state_q == DONE);
  assign diff  = diff_q;
  assign a_s   = as_q;
  assign b_s   = bs_q;
  assign s_s   = ss_q;
  assign eq    = eq_q;
  assign ltu   = ltu_q;

endmodule

// File: tb/tb_compare_flag_gen_serial.sv
// Directed bench for compare_flag_gen_serial.
// Ports: drives clk, rst_n, start, a, b; checks all outputs.
module tb_compare_flag_gen_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, valid;
  logic [31:0] diff;
  logic        a_s, b_s, s_s, eq, ltu;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] got, exp_v;
  int cyc, bcnt;

  compare_flag_gen_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .valid(valid),
    .diff(diff), .a_s(a_s), .b_s(b_s), .s_s(s_s),
    .eq(eq), .ltu(ltu)
  );

  always #5 clk = ~clk;

  // Caller stands at a negedge; start is accepted on
  // the next posedge and dropped right after.
  task automatic kick(input logic [31:0] av,
                      input logic [31:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts RUN cycles until valid, bounded at 40.
  task automatic wait_valid(output int c, output int bc);
    c = 0;
    bc = 0;
    while (c < 40) begin
      @(negedge clk);
      if (valid) break;
      c++;
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({busy, valid, diff, a_s, b_s, s_s, eq, ltu} !== 38'd0) begin
      n_err++;
      $display("FAIL reset: got %h required 0",
               {busy, valid, diff, a_s, b_s, s_s, eq, ltu});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_equal;
    kick(32'd5, 32'd5);
    wait_valid(cyc, bcnt);
    n_cmp++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL eq_latency: got %0d required 8", cyc);
    end
    n_cmp++;
    if (bcnt !== 8) begin
      n_err++;
      $display("FAIL eq_busy: got %0d required 8", bcnt);
    end
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL eq_result: got %h required %h", got, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if ({valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL eq_pulse: got %b required 00", {valid, busy});
    end
  endtask

  task automatic test_signs;
    kick(32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if ({a_s, b_s, diff, eq} !== {2'b10, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL sign_accept: got %h required %h",
               {a_s, b_s, diff, eq}, {2'b10, 32'h0, 1'b1});
    end
    wait_valid(cyc, bcnt);
    n_cmp++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL sign_latency: got %0d required 8", cyc);
    end
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL sign_result: got %h required %h", got, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic slt;
    kick(32'h8000_0000, 32'h1);
    wait_valid(cyc, bcnt);
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL ovf_result: got %h required %h", got, exp_v);
    end
    slt = (a_s & ~b_s) | (~eq & s_s & (~b_s | a_s));
    n_cmp++;
    if (slt !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_slt: got %b required 1", slt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    kick(32'd3, 32'd7);
    wait_valid(cyc, bcnt);
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL b2b_first: got %h required %h", got, exp_v);
    end
    kick(32'd7, 32'd3);
    n_cmp++;
    if ({busy, diff, ltu} !== {1'b1, 32'hFFFF_FFFC, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_hold: got %h required %h",
               {busy, diff, ltu}, {1'b1, 32'hFFFF_FFFC, 1'b1});
    end
    wait_valid(cyc, bcnt);
    n_cmp++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d required 8", cyc);
    end
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL b2b_second: got %h required %h", got, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int extra;
    int bz;
    start = 1'b1;
    a = 32'd10;
    b = 32'd2;
    @(posedge clk);
    #1;
    a = '0;
    b = '0;
    wait_valid(cyc, bcnt);
    start = 1'b0;
    n_cmp++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL ign_latency: got %0d required 8", cyc);
    end
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL ign_result: got %h required %h", got, exp_v);
    end
    extra = 0;
    bz = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) extra++;
      if (busy) bz++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL ign_extra_valid: got %0d required 0", extra);
    end
    n_cmp++;
    if (bz !== 0) begin
      n_err++;
      $display("FAIL ign_busy: got %0d required 0", bz);
    end
  endtask

  task automatic test_abort;
    int vc;
    kick(32'd1, 32'd2);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, valid, diff, a_s, b_s, s_s, eq, ltu} !== 38'd0) begin
      n_err++;
      $display("FAIL abort_zero: got %h required 0",
               {busy, valid, diff, a_s, b_s, s_s, eq, ltu});
    end
    @(negedge clk);
    rst_n = 1'b1;
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) vc++;
    end
    n_cmp++;
    if (vc !== 0) begin
      n_err++;
      $display("FAIL abort_valid: got %0d required 0", vc);
    end
    kick(32'd2, 32'd2);
    wait_valid(cyc, bcnt);
    got = {diff, a_s, b_s, s_s, eq, ltu};
    exp_v = {32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp_v || cyc !== 8) begin
      n_err++;
      $display("FAIL abort_after: got %h/%0d required %h/8",
               got, cyc, exp_v);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signs();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compare_flag_gen_serial.md
Name: compare_flag_gen_serial

Overview:
- Multi-cycle, digit-serial subtractor that computes A − B LSB-first, DIGIT bits per cycle.
- Produces the flag set consumed by the ALU comparators: operand signs, difference sign, equality and unsigned borrow.
- Sits in front of the signed/unsigned less-than comparators in the area-reduced ALU path, where one full-width subtractor is replaced by a DIGIT-wide slice.
- Simple start/valid handshake; one operation in flight.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle. DIGIT = WIDTH gives a one-cycle RUN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy = 0.
- a  in  WIDTH  minuend; sampled with an accepted start.
- b  in  WIDTH  subtrahend; sampled with an accepted start.
- busy  out  1  high while RUN.
- valid  out  1  one-cycle pulse; result outputs are valid from this pulse on.
- diff  out  WIDTH  A − B, modulo 2^WIDTH.
- a_s  out  1  sign bit of A (a[WIDTH-1]).
- b_s  out  1  sign bit of B.
- s_s  out  1  sign bit of diff.
- eq  out  1  1 when diff == 0.
- ltu  out  1  unsigned A < B; equals the inverted final carry.

Behaviour:
- Reset (asynchronous, rst_n = 0): state = IDLE; busy, valid, diff, a_s, b_s, s_s, eq, ltu all 0; internal operand and count registers cleared.
- Reset mid-RUN aborts the operation: no valid pulse, outputs return to 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start = 1 at an edge:
  - latch a and ~b into shift registers;
  - set carry = 1, count = 0, eq accumulator = 1;
  - latch a_s and b_s from the operand MSBs;
  - go to RUN.
- IDLE or DONE, start = 0: DONE goes to IDLE; IDLE stays in IDLE.
- RUN, each edge:
  - {c, d} = a_lo + nb_lo + carry, using the low DIGIT bits;
  - shift d into diff from the top; shift both operand registers right by DIGIT;
  - carry ← c;
  - eq_acc ← eq_acc & (d == 0);
  - count ← count + 1.
- RUN exit: on the edge where count == WIDTH/DIGIT − 1:
  - go to DONE;
  - register s_s = final diff MSB, eq = final eq_acc, ltu = ~c, and update diff;
  - valid = 1 for the following cycle only.
- Latency: start accepted at edge k gives valid high in the cycle after edge k + WIDTH/DIGIT. The default configuration (N = 8) has 8 cycles of latency.
- busy = 1 exactly in RUN. start is ignored while busy, and a/b changes during RUN have no effect.
- Back-to-back operations: start accepted in the DONE cycle, so no dead cycle between results.
- Result outputs hold their last values through IDLE until the next operation completes.
- diff, s_s, eq and ltu are not updated mid-RUN; they change only on the completing edge.
- a_s and b_s update on the accepting edge.
- Overflow is not flagged. Signed less-than is (a_s & ~b_s) | (~eq & s_s & (~b_s | a_s)), computed by the downstream comparator.

Test Plan:
- a=5, b=5, start 1 cycle: busy 8 cycles, then valid 1 cycle with diff=0, eq=1, s_s=0, ltu=0, a_s=0, b_s=0.
- a=0xFFFFFFFF, b=1: diff=0xFFFFFFFE, a_s=1, b_s=0, s_s=1, eq=0, ltu=0.
- a=0x80000000, b=1: diff=0x7FFFFFFF, a_s=1, s_s=0, eq=0, ltu=0. Downstream signed LT evaluates to 1 (overflow case).
- a=3, b=7: diff=0xFFFFFFFC, s_s=1, ltu=1, eq=0. Then start again in the DONE cycle with a=7, b=3: second valid arrives 8 cycles later with diff=4, ltu=0.
- Start at a=10, b=2; during RUN hold start=1 and drive a=0, b=0: single result diff=8, eq=0. The ignored start gives no extra valid. A new op begins only if start is still high in DONE.
- Start a=1, b=2; assert rst_n=0 asynchronously after 4 RUN cycles: all outputs 0 immediately, no valid. Release, then start a=2, b=2: valid with eq=1.
